fetch_unit: RTL and testbench

//  Instruction-fetch stage of the MIPS datapath, directly upstream of Extend.

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// State encodings, widths and the per-cycle control bundle.
package fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam int IMM_W   = 16;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   localparam logic [1:0] BUSY  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] PEND  = 2'd2;

   localparam logic [1:0] ASEL_HOLD  = 2'd0;
   localparam logic [1:0] ASEL_INC   = 2'd1;
   localparam logic [1:0] ASEL_REDIR = 2'd2;
   localparam logic [1:0] ASEL_TGT   = 2'd3;

   typedef struct packed {
      logic       ld_mem;
      logic       ld_pend;
      logic       park;
      logic [1:0] asel;
      logic       tgt_wr;
      logic       v_set;
      logic       v_clr;
   } ctl_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, hold-until-ready imem handshake,
// one-deep park buffer for decode stalls, redirect flush/drain.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [31:0]        redirectPC,
   output logic               imemReq,
   output logic [31:0]        imemAddr,
   input  logic               imemReady,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instr,
   output logic               instrValid,
   output logic [31:0]        pc,
   output logic [31:0]        pcPlus4,
   output logic [IMM_W-1:0]   imm16
);

   logic [1:0]         state;
   logic [1:0]         state_nx;
   logic [31:0]        reqAddr;
   logic [31:0]        tgtPC;
   logic [INSTR_W-1:0] pendBuf;
   logic [31:0]        pendPC;
   ctl_t               ctl;
   logic               hs;
   logic               hold;

   assign hs   = imemReq & imemReady;
   assign hold = instrValid & stall;

   always_ff @(posedge clk) begin
      if (rst) state <= BUSY;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         BUSY: begin
            if (hs & ~redirect & hold) state_nx = PEND;
            else if (~hs & redirect)   state_nx = DRAIN;
         end
         DRAIN: if (hs) state_nx = BUSY;
         PEND: if (redirect | ~stall) state_nx = BUSY;
         default: state_nx = BUSY;
      endcase
   end

   always_comb begin
      ctl     = '0;
      imemReq = (state != PEND) & ~rst;
      unique case (state)
         BUSY: begin
            unique case (1'b1)
               hs & redirect: begin
                  ctl.asel  = ASEL_REDIR;
                  ctl.v_clr = 1'b1;
               end
               hs & ~redirect & ~hold: begin
                  ctl.ld_mem = 1'b1;
                  ctl.asel   = ASEL_INC;
                  ctl.v_set  = 1'b1;
               end
               hs & ~redirect & hold: begin
                  ctl.park = 1'b1;
                  ctl.asel = ASEL_INC;
               end
               ~hs & redirect: begin
                  ctl.tgt_wr = 1'b1;
                  ctl.v_clr  = 1'b1;
               end
               default: ctl.v_clr = instrValid & ~stall;
            endcase
         end
         DRAIN: begin
            ctl.tgt_wr = redirect;
            ctl.v_clr  = 1'b1;
            if (hs) ctl.asel = redirect ? ASEL_REDIR : ASEL_TGT;
         end
         PEND: begin
            unique case (1'b1)
               redirect: begin
                  ctl.asel  = ASEL_REDIR;
                  ctl.v_clr = 1'b1;
               end
               ~redirect & ~stall: begin
                  ctl.ld_pend = 1'b1;
                  ctl.v_set   = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Datapath registers driven by the decoded control bundle.
   always_ff @(posedge clk) begin
      if (rst) begin
         reqAddr    <= RESET_PC;
         instr      <= '0;
         pc         <= '0;
         instrValid <= 1'b0;
         pendBuf    <= '0;
         pendPC     <= '0;
         tgtPC      <= '0;
      end else begin
         if (ctl.ld_mem) begin
            instr <= imemData;
            pc    <= reqAddr;
         end
         if (ctl.ld_pend) begin
            instr <= pendBuf;
            pc    <= pendPC;
         end
         if (ctl.park) begin
            pendBuf <= imemData;
            pendPC  <= reqAddr;
         end
         if (ctl.tgt_wr) tgtPC <= redirectPC;
         unique case (ctl.asel)
            ASEL_INC:   reqAddr <= reqAddr + 32'd4;
            ASEL_REDIR: reqAddr <= redirectPC;
            ASEL_TGT:   reqAddr <= tgtPC;
            default:    reqAddr <= reqAddr;
         endcase
         if (ctl.v_set)      instrValid <= 1'b1;
         else if (ctl.v_clr) instrValid <= 1'b0;
      end
   end

   assign imemAddr = reqAddr;
   assign pcPlus4  = pc + 32'd4;
   assign imm16    = instr[IMM_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory, queue-based
// reference model checked every cycle, plus directed literal checks.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPC;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemReady;
   logic [31:0] imemData;
   logic [31:0] instr;
   logic        instrValid;
   logic [31:0] pc;
   logic [31:0] pcPlus4;
   logic [15:0] imm16;

   int nchk = 0;
   int nerr = 0;
   int lat  = 0;
   int wcnt = 0;
   bit started = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirectPC(redirectPC), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemReady(imemReady), .imemData(imemData), .instr(instr),
      .instrValid(instrValid), .pc(pc), .pcPlus4(pcPlus4), .imm16(imm16)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      if (a == 32'hFFFF_FFFC) return 32'h2008_ABCD;
      return {a[15:0], ~a[15:0]};
   endfunction

   // memory: ready once the request has waited lat cycles
   always @(posedge clk) begin
      if (rst || !imemReq || imemReady) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end
   assign imemReady = imemReq && (wcnt >= lat);
   assign imemData  = word(imemAddr);

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: queue of delivered-but-unconsumed words (max 2)
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;
   ent_t        q[$];
   logic [31:0] m_fetch = RESET_PC_DEF;
   logic [31:0] m_tgt   = 32'h0;
   bit          m_drain = 0;

   always @(posedge clk) begin
      bit req, hs;
      req = (q.size() < 2) && !rst;
      hs  = req && (wcnt >= lat);
      if (rst) begin
         q.delete();
         m_fetch = RESET_PC_DEF;
         m_drain = 0;
      end else if (redirect) begin
         q.delete();
         if (hs || !req) begin
            m_fetch = redirectPC;
            m_drain = 0;
         end else begin
            m_drain = 1;
            m_tgt   = redirectPC;
         end
      end else begin
         if (q.size() > 0 && !stall) void'(q.pop_front());
         if (hs) begin
            if (m_drain) begin
               m_fetch = m_tgt;
               m_drain = 0;
            end else begin
               q.push_back('{m_fetch, word(m_fetch)});
               m_fetch = m_fetch + 32'd4;
            end
         end
      end
      started = 1;
   end

   always @(negedge clk) begin
      if (started) begin
         logic er;
         er = (q.size() < 2) && !rst;
         chk("imemReq", {31'b0, imemReq}, {31'b0, er});
         if (er) chk("imemAddr", imemAddr, m_fetch);
         chk("instrValid", {31'b0, instrValid}, {31'b0, q.size() > 0});
         if (q.size() > 0) begin
            chk("instr", instr, q[0].d);
            chk("pc", pc, q[0].a);
            chk("pcPlus4", pcPlus4, q[0].a + 32'd4);
            chk("imm16", {16'b0, imm16}, {16'b0, q[0].d[15:0]});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1; stall = 0; redirect = 0; redirectPC = 0; lat = 0;
      step(); step();
      chk("rst_req", {31'b0, imemReq}, 32'd0);
      chk("rst_valid", {31'b0, instrValid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_addr", imemAddr, 32'h3000);
      rst = 0;
      // zero-wait streaming
      step();
      chk("t1_pc0", pc, 32'h3000);
      chk("t1_v0", {31'b0, instrValid}, 32'd1);
      chk("t1_a1", imemAddr, 32'h3004);
      step();
      chk("t1_pc1", pc, 32'h3004);
      chk("t1_a2", imemAddr, 32'h3008);
      step();
      chk("t1_instr", instr, 32'h3008_CFF7);
      chk("t1_imm", {16'b0, imm16}, 32'h0000_CFF7);
      // slow memory
      rst = 1; lat = 3;
      step();
      rst = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_addr", imemAddr, 32'h3000);
         chk("t2_v", {31'b0, instrValid}, 32'd0);
      end
      step();
      chk("t2_pc", pc, 32'h3000);
      chk("t2_a", imemAddr, 32'h3004);
      // stall parks the next word
      lat = 0; stall = 1;
      step();
      chk("t3_req", {31'b0, imemReq}, 32'd0);
      chk("t3_pc", pc, 32'h3000);
      step();
      chk("t3_pc_hold", pc, 32'h3000);
      chk("t3_v_hold", {31'b0, instrValid}, 32'd1);
      stall = 0;
      step();
      chk("t3_pc_pend", pc, 32'h3004);
      chk("t3_a", imemAddr, 32'h3008);
      // redirect during a wait on 3008
      lat = 2; redirect = 1; redirectPC = 32'h4000;
      step();
      redirect = 0;
      chk("t4_v", {31'b0, instrValid}, 32'd0);
      chk("t4_a_old", imemAddr, 32'h3008);
      step();
      chk("t4_a_old2", imemAddr, 32'h3008);
      step();
      chk("t4_a_new", imemAddr, 32'h4000);
      chk("t4_v2", {31'b0, instrValid}, 32'd0);
      lat = 0;
      step();
      chk("t4_pc", pc, 32'h4000);
      // redirect with stall, then PC wrap
      stall = 1; redirect = 1; redirectPC = 32'hFFFF_FFFC;
      step();
      chk("t5_v", {31'b0, instrValid}, 32'd0);
      chk("t5_a", imemAddr, 32'hFFFF_FFFC);
      stall = 0; redirect = 0;
      step();
      chk("t6_instr", instr, 32'h2008_ABCD);
      chk("t6_imm", {16'b0, imm16}, 32'h0000_ABCD);
      chk("t6_pc", pc, 32'hFFFF_FFFC);
      chk("t6_pc4", pcPlus4, 32'h0);
      chk("t6_a", imemAddr, 32'h0);
      step();
      chk("t6_pcw", pc, 32'h0);
      // redirect while parked
      stall = 1;
      step();
      chk("t7_req", {31'b0, imemReq}, 32'd0);
      redirect = 1; redirectPC = 32'h5000;
      step();
      chk("t7_a", imemAddr, 32'h5000);
      chk("t7_v", {31'b0, instrValid}, 32'd0);
      redirect = 0; stall = 0;
      // mixed traffic, model-checked each cycle
      for (int i = 0; i < 300; i++) begin
         step();
         stall      = ($urandom_range(0, 2) == 0);
         redirect   = ($urandom_range(0, 12) == 0);
         redirectPC = $urandom & 32'hFFFF_FFFC;
         lat        = $urandom_range(0, 2);
      end
      // reset abandons an outstanding request
      stall = 0; redirect = 0; lat = 3;
      step(); step();
      rst = 1;
      step();
      chk("t8_req", {31'b0, imemReq}, 32'd0);
      rst = 0;
      #1;
      chk("t8_a", imemAddr, 32'h3000);
      lat = 0;
      for (int i = 0; i < 5; i++) step();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
